// File: rtl/dir_cmd_gen_if.sv
// Stick sample handshake between the stick sampler (master) and
// dir_cmd_gen (slave).
//   stick_valid : master -> slave, sample on stick_pos is valid
//   stick_ready : slave -> master, slave can accept a sample this cycle
//   stick_pos   : master -> slave, signed stick position -128..127
interface dir_cmd_gen_if;
  logic              stick_valid;
  logic              stick_ready;
  logic signed [7:0] stick_pos;

  modport master (output stick_valid, output stick_pos, input stick_ready);
  modport slave  (input stick_valid, input stick_pos, output stick_ready);
endinterface

// File: rtl/dir_cmd_gen.sv
// dir_cmd_gen - pitch-direction command generator.
// Quantizes signed stick samples to a target {dir, speed} and slews the
// 3-bit cmds word one speed level per STEP_CYCLES edges toward that target.
// A direction reversal ramps down through STOP before dir flips.
//
// Ports:
//   clk        : system clock
//   resetn     : asynchronous active-low reset
//   stick      : sample handshake (dir_cmd_gen_if.slave)
//   cmds       : {dir, speed[1:0]}, speed 0=STOP 1=SLOW 2=MEDIUM 3=FAST
//   cmd_strobe : one-cycle pulse after each edge that changes cmds
//   settled    : cmds equals the target
//   wdog_trip  : failsafe active
//
// Optional feature macro: DIR_CMD_GEN_WDOG_EN
//   Defined   : a stale-input watchdog forces a STOP target after
//               WDOG_CYCLES cycles without an accepted sample.
//   Undefined : no watchdog, wdog_trip tied low.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SETTLED  | cmds equals target, step timer held at 0
// RAMP     | same dir (or STOP target), speed stepping toward target
// BRAKE    | dir differs, speed > STOP, stepping down
// FLIP     | dir differs, speed = STOP, next tick inverts dir; no samples
module dir_cmd_gen #(
  parameter int unsigned STEP_CYCLES = 4,
  parameter int unsigned TH_SLOW     = 16,
  parameter int unsigned TH_MED      = 48,
  parameter int unsigned TH_FAST     = 96,
  parameter int unsigned WDOG_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               resetn,
  dir_cmd_gen_if.slave       stick,
  output logic [2:0]         cmds,
  output logic               cmd_strobe,
  output logic               settled,
  output logic               wdog_trip
);

  typedef enum logic [1:0] {
    ST_SETTLED = 2'd0,
    ST_RAMP    = 2'd1,
    ST_BRAKE   = 2'd2,
    ST_FLIP    = 2'd3
  } state_e;

  localparam logic [15:0] STEP_LAST = 16'(STEP_CYCLES - 1);
  localparam logic [8:0]  TH_SLOW_L = 9'(TH_SLOW);
  localparam logic [8:0]  TH_MED_L  = 9'(TH_MED);
  localparam logic [8:0]  TH_FAST_L = 9'(TH_FAST);

  // Elaboration guard: an out-of-range parameter set shows up by name in
  // the hierarchy.
  if (STEP_CYCLES < 2 || STEP_CYCLES > 65535 || WDOG_CYCLES < 1) begin : g_illegal_param_set
  end

  state_e      state_q, state_d;
  logic        cmd_dir_q, cmd_dir_d;
  logic [1:0]  cmd_spd_q, cmd_spd_d;
  logic        tgt_dir_q, tgt_dir_d;
  logic [1:0]  tgt_spd_q, tgt_spd_d;
  logic [15:0] timer_q, timer_d;
  logic        strobe_q, strobe_d;
  logic        armed_q, armed_d;

  logic        accept;
  logic        tick;
  logic        wdog_fire;
  logic signed [8:0] pos_ext;
  logic [8:0]  mag;
  logic [1:0]  q_spd;

  function automatic logic cmd_match(input logic cdir, input logic [1:0] cspd,
                                     input logic tdir, input logic [1:0] tspd);
    // At STOP the dir bit is irrelevant to "equal": a STOP target never
    // forces a flip.
    return (cspd == tspd) && ((cspd == 2'd0) || (cdir == tdir));
  endfunction

  assign accept = stick.stick_valid && stick.stick_ready;
  assign tick   = (state_q != ST_SETTLED) && (timer_q == STEP_LAST);

  always_comb begin
    pos_ext = {stick.stick_pos[7], stick.stick_pos};
    mag     = pos_ext[8] ? 9'(-pos_ext) : 9'(pos_ext);
    if (mag >= TH_FAST_L)      q_spd = 2'd3;
    else if (mag >= TH_MED_L)  q_spd = 2'd2;
    else if (mag >= TH_SLOW_L) q_spd = 2'd1;
    else                       q_spd = 2'd0;
  end

`ifdef DIR_CMD_GEN_WDOG_EN
  localparam int unsigned WD_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_trip_q, wdog_trip_d;

  always_comb begin
    wdog_fire   = !accept && (wdog_cnt_q == WD_LAST);
    if (accept)                    wdog_cnt_d = '0;
    else if (wdog_cnt_q == WD_MAX) wdog_cnt_d = wdog_cnt_q;
    else                           wdog_cnt_d = wdog_cnt_q + 1'b1;
    wdog_trip_d = accept ? 1'b0 : (wdog_trip_q | wdog_fire);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_q  <= '0;
      wdog_trip_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_trip_q <= wdog_trip_d;
    end
  end

  assign wdog_trip = wdog_trip_q;
`else
  assign wdog_fire = 1'b0;
  assign wdog_trip = 1'b0;
`endif

  // Target update; a STOP target keeps the previous dir.
  always_comb begin
    tgt_dir_d = tgt_dir_q;
    tgt_spd_d = tgt_spd_q;
    if (accept) begin
      tgt_spd_d = q_spd;
      if (q_spd != 2'd0) tgt_dir_d = ~stick.stick_pos[7];
    end else if (wdog_fire) begin
      tgt_spd_d = 2'd0;
    end
  end

  // One step toward the target per tick. A sample accepted on a tick edge
  // already steers that tick. Until cmds first leaves STOP after reset the
  // dir bit carries no history, so the first move takes the target dir
  // directly instead of spending a tick on a flip.
  always_comb begin
    cmd_dir_d = cmd_dir_q;
    cmd_spd_d = cmd_spd_q;
    if (tick && !cmd_match(cmd_dir_q, cmd_spd_q, tgt_dir_d, tgt_spd_d)) begin
      if (tgt_spd_d == 2'd0 || cmd_dir_q == tgt_dir_d) begin
        if (cmd_spd_q < tgt_spd_d) cmd_spd_d = cmd_spd_q + 2'd1;
        else                       cmd_spd_d = cmd_spd_q - 2'd1;
      end else if (!armed_q) begin
        cmd_dir_d = tgt_dir_d;
        cmd_spd_d = 2'd1;
      end else if (cmd_spd_q != 2'd0) begin
        cmd_spd_d = cmd_spd_q - 2'd1;
      end else begin
        cmd_dir_d = tgt_dir_d;
      end
    end
    armed_d  = armed_q | (cmd_spd_d != 2'd0);
    strobe_d = {cmd_dir_d, cmd_spd_d} != {cmd_dir_q, cmd_spd_q};
  end

  // Next state follows from the post-edge command and target.
  always_comb begin
    if (cmd_match(cmd_dir_d, cmd_spd_d, tgt_dir_d, tgt_spd_d))
      state_d = ST_SETTLED;
    else if (cmd_dir_d != tgt_dir_d && cmd_spd_d != 2'd0)
      state_d = ST_BRAKE;
    else if (cmd_dir_d != tgt_dir_d && armed_q)
      state_d = ST_FLIP;
    else
      state_d = ST_RAMP;
  end

  // Timer is not restarted by a retarget; it only clears on a tick or when
  // settling.
  always_comb begin
    if (state_q == ST_SETTLED || state_d == ST_SETTLED || tick)
      timer_d = 16'd0;
    else
      timer_d = timer_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_SETTLED;
      cmd_dir_q <= 1'b0;
      cmd_spd_q <= 2'd0;
      tgt_dir_q <= 1'b0;
      tgt_spd_q <= 2'd0;
      timer_q   <= 16'd0;
      strobe_q  <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_dir_q <= cmd_dir_d;
      cmd_spd_q <= cmd_spd_d;
      tgt_dir_q <= tgt_dir_d;
      tgt_spd_q <= tgt_spd_d;
      timer_q   <= timer_d;
      strobe_q  <= strobe_d;
      armed_q   <= armed_d;
    end
  end

  always_comb begin
    settled           = (state_q == ST_SETTLED);
    stick.stick_ready = (state_q != ST_FLIP);
    cmds              = {cmd_dir_q, cmd_spd_q};
    cmd_strobe        = strobe_q;
  end

endmodule

// File: tb/tb_dir_cmd_gen.sv
module tb_dir_cmd_gen;
  localparam int STEP = 4;
  localparam int WD   = 32;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] cmds;
  logic       cmd_strobe, settled, wdog_trip;

  dir_cmd_gen_if stick_if();

  dir_cmd_gen #(.STEP_CYCLES(STEP), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .resetn(resetn), .stick(stick_if),
    .cmds(cmds), .cmd_strobe(cmd_strobe), .settled(settled), .wdog_trip(wdog_trip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: commanded and target {dir, speed}, the edge index of
  // the next scheduled step, and the watchdog age.
  int m_cdir, m_cspd, m_tdir, m_tspd, m_now, m_next, m_cnt;
  bit m_armed, m_strobe, m_trip;

  function automatic bit m_match();
    return (m_cspd == m_tspd) && (m_cspd == 0 || m_cdir == m_tdir);
  endfunction

  function automatic bit m_ready();
    return !(m_armed && m_cdir != m_tdir && m_cspd == 0 && m_tspd != 0);
  endfunction

  function automatic logic [2:0] m_cmds();
    return 3'(m_cdir * 4 + m_cspd);
  endfunction

  function automatic int quant(int pos);
    int mag;
    mag = (pos < 0) ? -pos : pos;
    if (mag >= 96) return 3;
    if (mag >= 48) return 2;
    if (mag >= 16) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_cdir = 0; m_cspd = 0; m_tdir = 0; m_tspd = 0;
    m_now = 0; m_next = 0; m_cnt = 0;
    m_armed = 0; m_strobe = 0; m_trip = 0;
  endtask

  task automatic model_edge(bit acc, int pos);
    bit was_settled, tick;
    int old_code, q;
    was_settled = m_match();
    tick = !was_settled && (m_now == m_next);
    old_code = m_cdir * 4 + m_cspd;
    if (acc) begin
      q = quant(pos);
      m_tspd = q;
      if (q != 0) m_tdir = (pos >= 0) ? 1 : 0;
      m_cnt = 0;
      m_trip = 0;
    end else begin
`ifdef DIR_CMD_GEN_WDOG_EN
      if (m_cnt < WD) begin
        m_cnt++;
        if (m_cnt == WD) begin m_trip = 1; m_tspd = 0; end
      end
`endif
    end
    if (tick && !m_match()) begin
      if (m_tspd == 0 || m_cdir == m_tdir) m_cspd += (m_cspd < m_tspd) ? 1 : -1;
      else if (!m_armed) begin m_cdir = m_tdir; m_cspd = 1; end
      else if (m_cspd > 0) m_cspd--;
      else m_cdir = m_tdir;
    end
    if (m_cspd != 0) m_armed = 1;
    m_strobe = (m_cdir * 4 + m_cspd) != old_code;
    if (tick) m_next = m_now + STEP;
    if (was_settled && !m_match()) m_next = m_now + STEP;
    m_now++;
  endtask

  task automatic do_edge();
    bit acc;
    int pos;
    acc = stick_if.stick_valid && m_ready();
    pos = stick_if.stick_pos;
    @(posedge clk);
    #1;
    model_edge(acc, pos);
  endtask

  task automatic send(int pos);
    stick_if.stick_valid = 1'b1;
    stick_if.stick_pos = 8'(pos);
    do_edge();
    stick_if.stick_valid = 1'b0;
  endtask

  task automatic apply_reset();
    stick_if.stick_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    stick_if.stick_valid = 1'b0;
    stick_if.stick_pos = 8'sd0;
    @(negedge clk);
    resetn = 1'b0;
    #2;
    checks++;
    if ({cmds, settled, stick_if.stick_ready, cmd_strobe, wdog_trip} !== 7'b000_1100) begin
      failures++;
      $display("FAIL reset_values got cmds=%b settled=%b ready=%b strobe=%b trip=%b exp 000 1 1 0 0",
               cmds, settled, stick_if.stick_ready, cmd_strobe, wdog_trip);
    end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) do_edge();
    checks++;
    if (cmds !== 3'b000 || settled !== 1'b1 || cmd_strobe !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got cmds=%b settled=%b strobe=%b exp 000 1 0", cmds, settled, cmd_strobe);
    end
    send(100);
    repeat (8) do_edge();
    checks++;
    if (cmds !== 3'b110 || cmd_strobe !== 1'b1) begin
      failures++;
      $display("FAIL reset_preramp got cmds=%b strobe=%b exp 110 1", cmds, cmd_strobe);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (cmds !== 3'b000 || cmd_strobe !== 1'b0 || settled !== 1'b1 || stick_if.stick_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_async got cmds=%b strobe=%b settled=%b ready=%b exp 000 0 1 1",
               cmds, cmd_strobe, settled, stick_if.stick_ready);
    end
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_ramp_up();
    int n_strobe;
    logic [2:0] exp_c;
    n_strobe = 0;
    apply_reset();
    send(100);
    checks++;
    if (cmds !== 3'b000 || settled !== 1'b0) begin
      failures++;
      $display("FAIL ramp_up_accept got cmds=%b settled=%b exp 000 0", cmds, settled);
    end
    for (int k = 1; k <= 14; k++) begin
      do_edge();
      exp_c = (k < 4) ? 3'b000 : (k < 8) ? 3'b101 : (k < 12) ? 3'b110 : 3'b111;
      checks++;
      if (cmds !== exp_c || settled !== (k >= 12) || cmd_strobe !== (k == 4 || k == 8 || k == 12)) begin
        failures++;
        $display("FAIL ramp_up edge %0d got cmds=%b settled=%b strobe=%b exp cmds=%b settled=%b",
                 k, cmds, settled, cmd_strobe, exp_c, (k >= 12));
      end
      if (cmd_strobe) n_strobe++;
    end
    checks++;
    if (n_strobe != 3) begin
      failures++;
      $display("FAIL ramp_up_strobes got %0d exp 3", n_strobe);
    end
  endtask

  task automatic test_reversal();
    logic [2:0] seq [7];
    int n_strobe, idx;
    seq = '{3'b111, 3'b110, 3'b101, 3'b100, 3'b000, 3'b001, 3'b010};
    n_strobe = 0;
    apply_reset();
    send(100);
    repeat (13) do_edge();
    send(-50);
    for (int k = 1; k <= 26; k++) begin
      do_edge();
      idx = (k / 4 > 6) ? 6 : k / 4;
      checks++;
      if (cmds !== seq[idx] || settled !== (k >= 24) || stick_if.stick_ready !== !(k >= 12 && k < 16)) begin
        failures++;
        $display("FAIL reversal edge %0d got cmds=%b settled=%b ready=%b exp cmds=%b settled=%b ready=%b",
                 k, cmds, settled, stick_if.stick_ready, seq[idx], (k >= 24), !(k >= 12 && k < 16));
      end
      if (cmd_strobe) n_strobe++;
    end
    checks++;
    if (n_strobe != 6) begin
      failures++;
      $display("FAIL reversal_strobes got %0d exp 6", n_strobe);
    end
  endtask

  task automatic test_stop_then_flip();
    logic [2:0] seq_a [4];
    logic [2:0] seq_b [5];
    int idx;
    seq_a = '{3'b111, 3'b110, 3'b101, 3'b100};
    seq_b = '{3'b100, 3'b000, 3'b001, 3'b010, 3'b011};
    apply_reset();
    send(100);
    repeat (13) do_edge();
    send(10);
    for (int k = 1; k <= 13; k++) begin
      do_edge();
      idx = (k / 4 > 3) ? 3 : k / 4;
      checks++;
      if (cmds !== seq_a[idx] || settled !== (k >= 12)) begin
        failures++;
        $display("FAIL stop_target edge %0d got cmds=%b settled=%b exp %b %b", k, cmds, settled, seq_a[idx], (k >= 12));
      end
    end
    send(-128);
    checks++;
    if (stick_if.stick_ready !== 1'b0) begin
      failures++;
      $display("FAIL flip_ready got %b exp 0", stick_if.stick_ready);
    end
    for (int k = 1; k <= 17; k++) begin
      do_edge();
      idx = (k / 4 > 4) ? 4 : k / 4;
      checks++;
      if (cmds !== seq_b[idx] || settled !== (k >= 16)) begin
        failures++;
        $display("FAIL flip_ramp edge %0d got cmds=%b settled=%b exp %b %b", k, cmds, settled, seq_b[idx], (k >= 16));
      end
    end
  endtask

  task automatic test_retarget();
    apply_reset();
    send(100);
    repeat (13) do_edge();
    send(10);
    repeat (13) do_edge();
    send(100);
    repeat (4) do_edge();
    checks++;
    if (cmds !== 3'b101 || cmd_strobe !== 1'b1) begin
      failures++;
      $display("FAIL retarget_pre got cmds=%b strobe=%b exp 101 1", cmds, cmd_strobe);
    end
    send(20);
    checks++;
    if (cmds !== 3'b101 || settled !== 1'b1 || cmd_strobe !== 1'b0) begin
      failures++;
      $display("FAIL retarget_settle got cmds=%b settled=%b strobe=%b exp 101 1 0", cmds, settled, cmd_strobe);
    end
    for (int k = 1; k <= 10; k++) begin
      do_edge();
      checks++;
      if (cmds !== 3'b101 || settled !== 1'b1 || cmd_strobe !== 1'b0) begin
        failures++;
        $display("FAIL retarget_hold edge %0d got cmds=%b settled=%b strobe=%b exp 101 1 0", k, cmds, settled, cmd_strobe);
      end
    end
    send(100);
    for (int k = 1; k <= 4; k++) begin
      do_edge();
      checks++;
      if (cmds !== ((k < 4) ? 3'b101 : 3'b110)) begin
        failures++;
        $display("FAIL retarget_timer edge %0d got cmds=%b exp %b", k, cmds, (k < 4) ? 3'b101 : 3'b110);
      end
    end
  endtask

  task automatic test_wdog();
    logic [2:0] exp_c;
    apply_reset();
    send(100);
`ifdef DIR_CMD_GEN_WDOG_EN
    for (int k = 1; k <= 50; k++) begin
      do_edge();
      exp_c = (k < 4) ? 3'b000 : (k < 8) ? 3'b101 : (k < 12) ? 3'b110 : (k < 36) ? 3'b111 :
              (k < 40) ? 3'b110 : (k < 44) ? 3'b101 : 3'b100;
      checks++;
      if (cmds !== exp_c || wdog_trip !== (k >= 32)) begin
        failures++;
        $display("FAIL wdog edge %0d got cmds=%b trip=%b exp %b %b", k, cmds, wdog_trip, exp_c, (k >= 32));
      end
    end
    send(100);
    checks++;
    if (wdog_trip !== 1'b0) begin
      failures++;
      $display("FAIL wdog_clear got trip=%b exp 0", wdog_trip);
    end
    for (int k = 1; k <= 12; k++) begin
      do_edge();
      exp_c = (k < 4) ? 3'b100 : (k < 8) ? 3'b101 : (k < 12) ? 3'b110 : 3'b111;
      checks++;
      if (cmds !== exp_c) begin
        failures++;
        $display("FAIL wdog_recover edge %0d got cmds=%b exp %b", k, cmds, exp_c);
      end
    end
`else
    for (int k = 1; k <= 60; k++) begin
      do_edge();
      exp_c = (k < 4) ? 3'b000 : (k < 8) ? 3'b101 : (k < 12) ? 3'b110 : 3'b111;
      checks++;
      if (cmds !== exp_c || wdog_trip !== 1'b0) begin
        failures++;
        $display("FAIL no_wdog edge %0d got cmds=%b trip=%b exp %b 0", k, cmds, wdog_trip, exp_c);
      end
    end
`endif
  endtask

  task automatic test_random();
    int edge_pos [16];
    int pos;
    edge_pos = '{0, 15, 16, 47, 48, 95, 96, 127, -128, -15, -16, -47, -48, -95, -96, -1};
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 1) == 0) pos = edge_pos[$urandom_range(0, 15)];
      else pos = int'($urandom_range(0, 255)) - 128;
      stick_if.stick_pos = 8'(pos);
      stick_if.stick_valid = ($urandom_range(0, 11) == 0);
      do_edge();
      checks++;
      if (cmds !== m_cmds() || cmd_strobe !== m_strobe || settled !== m_match() ||
          stick_if.stick_ready !== m_ready() || wdog_trip !== m_trip) begin
        failures++;
        $display("FAIL random edge %0d got cmds=%b strobe=%b settled=%b ready=%b trip=%b exp %b %b %b %b %b",
                 n, cmds, cmd_strobe, settled, stick_if.stick_ready, wdog_trip,
                 m_cmds(), m_strobe, m_match(), m_ready(), m_trip);
      end
    end
    stick_if.stick_valid = 1'b0;
  endtask

  initial begin
    stick_if.stick_valid = 1'b0;
    stick_if.stick_pos = 8'sd0;
    model_reset();
    test_reset();
    test_ramp_up();
    test_reversal();
    test_stop_then_flip();
    test_retarget();
    test_wdog();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
